// File: rtl/uart_rx_gen2_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_gen2_pkg
// Shared types and helpers for the uart_rx_gen2 receiver:
//   rx_state_t  : receiver FSM state encoding
//   clampWl     : limits a programmed word length to 5..maxWl
//   dataParity  : XOR of the lowest wl bits of a (up to 9-bit) data word
// -----------------------------------------------------------------------------
package uart_rx_gen2_pkg;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_PAR   = 3'd3,
      RX_STOP1 = 3'd4,
      RX_STOP2 = 3'd5,
      RX_MWAIT = 3'd6
   } rx_state_t;

   localparam logic [3:0] MIN_WL = 4'd5;

   // Word lengths below 5 read as 5, above the build maximum read as the maximum.
   function automatic logic [3:0] clampWl(input logic [3:0] wl, input logic [3:0] maxWl);
      logic [3:0] res;
      if (wl < MIN_WL) begin
         res = MIN_WL;
      end else if (wl > maxWl) begin
         res = maxWl;
      end else begin
         res = wl;
      end
      return res;
   endfunction

   // Parity (XOR) over data bits 0..wl-1 only.
   function automatic logic dataParity(input logic [8:0] data, input logic [3:0] wl);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < int'(wl)) begin
            p = p ^ data[i];
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_gen2_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_gen2_sampler
// Brings the asynchronous serial input into the CLK domain and times each bit.
//   CLK, RST_N : clock / asynchronous active-low reset
//   RXCLK      : one-CLK enable at OVERSAMPLE x baud
//   CLR        : holds the tick counter at 0 (line idle or abort)
//   SIN        : raw serial input
//   sSin       : synchronised serial input
//   bitMid     : RXCLK cycle at tick M+1, voted is valid in this cycle
//   bitEnd     : RXCLK cycle at tick OVERSAMPLE-1
//   voted      : 2-of-3 majority of sSin at ticks M-1, M, M+1
// -----------------------------------------------------------------------------
module uart_rx_gen2_sampler #(
   parameter int OVERSAMPLE = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic RXCLK,
   input  logic CLR,
   input  logic SIN,
   output logic sSin,
   output logic bitMid,
   output logic bitEnd,
   output logic voted
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] TICK_MLO  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] TICK_MHI  = TICK_W'(OVERSAMPLE / 2 + 1);

   logic             sync1_r;
   logic             sync2_r;
   logic [TICK_W-1:0] tick_r;
   logic             smpLo_r;
   logic             smpMid_r;

   // Two-flop synchroniser; idles high so reset looks like a quiet line.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= SIN;
         sync2_r <= sync1_r;
      end
   end

   // Tick position within the current bit, advanced only on RXCLK.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_r <= {TICK_W{1'b0}};
      end else if (CLR) begin
         tick_r <= {TICK_W{1'b0}};
      end else if (RXCLK) begin
         if (tick_r == TICK_LAST) begin
            tick_r <= {TICK_W{1'b0}};
         end else begin
            tick_r <= tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // First two of the three vote samples; the third is the live sSin at M+1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         smpLo_r  <= 1'b1;
         smpMid_r <= 1'b1;
      end else if (RXCLK) begin
         if (tick_r == TICK_MLO) begin
            smpLo_r <= sync2_r;
         end
         if (tick_r == TICK_MID) begin
            smpMid_r <= sync2_r;
         end
      end
   end

   // Strobes and majority vote.
   always_comb begin
      sSin   = sync2_r;
      bitMid = RXCLK & (tick_r == TICK_MHI);
      bitEnd = RXCLK & (tick_r == TICK_LAST);
      voted  = (smpLo_r & smpMid_r) | (smpLo_r & sync2_r) | (smpMid_r & sync2_r);
   end

endmodule

// File: rtl/uart_rx_gen2.sv
// -----------------------------------------------------------------------------
// uart_rx_gen2
// UART receive deserialiser with majority-vote sampling, false-start rejection,
// optional second stop bit check, one-entry valid/ready holding register with
// overrun pulse, and character-timeout level.
//   CLK, RST_N          : clock / asynchronous active-low reset
//   RXCLK               : OVERSAMPLE x baud enable from the baud generator
//   RXCLEAR             : synchronous abort (FSM idle, DVALID/TIMEOUT cleared)
//   WL, STB, PEN, EPS, SP : line format (word length, 2 stop bits, parity)
//   SIN                 : asynchronous serial input
//   DOUT, PE, FE, BI    : received word and its status
//   DVALID / DREADY     : holding register handshake
//   OVERRUN             : one-CLK pulse when a completed character is dropped
//   TIMEOUT             : unread data with the line idle for TO_BITS bit-times
// -----------------------------------------------------------------------------
module uart_rx_gen2
   import uart_rx_gen2_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_W     = 8,
   parameter int TO_BITS    = 40
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RXCLK,
   input  logic              RXCLEAR,
   input  logic [3:0]        WL,
   input  logic              STB,
   input  logic              PEN,
   input  logic              EPS,
   input  logic              SP,
   input  logic              SIN,
   output logic [DATA_W-1:0] DOUT,
   output logic              PE,
   output logic              FE,
   output logic              BI,
   output logic              DVALID,
   input  logic              DREADY,
   output logic              OVERRUN,
   output logic              TIMEOUT
);

   localparam logic [3:0] MAX_WL = 4'(DATA_W);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam int TO_W = $clog2(TO_BITS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_BITS - 1);

   rx_state_t          state_r;
   rx_state_t          nextState_s;
   logic               sSin_s;
   logic               bitMid_s;
   logic               bitEnd_s;
   logic               voted_s;
   logic               tickClr_s;
   logic [3:0]         wlEff_s;
   logic [3:0]         bitCnt_r;
   logic [DATA_W-1:0]  data_r;
   logic               parBit_r;
   logic               stop1Bit_r;
   logic               startDet_s;
   logic               shiftEn_s;
   logic               parCap_s;
   logic               stop1Cap_s;
   logic               complete_s;
   logic               feNow_s;
   logic               peNow_s;
   logic               biNow_s;
   logic               dataPar_s;
   logic               handshake_s;
   logic [TICK_W-1:0]  toTick_r;
   logic [TO_W-1:0]    toBits_r;

   // Bit timing is free-running during a frame and parked at 0 while idle.
   always_comb begin
      tickClr_s = (state_r == RX_IDLE) | RXCLEAR;
      wlEff_s   = clampWl(WL, MAX_WL);
   end

   uart_rx_gen2_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .RXCLK  (RXCLK),
      .CLR    (tickClr_s),
      .SIN    (SIN),
      .sSin   (sSin_s),
      .bitMid (bitMid_s),
      .bitEnd (bitEnd_s),
      .voted  (voted_s)
   );

   // FSM state register; abort overrides every transition.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= RX_IDLE;
      end else if (RXCLEAR) begin
         state_r <= RX_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         RX_IDLE: begin
            if (RXCLK && !sSin_s) begin
               nextState_s = RX_START;
            end else begin
               nextState_s = RX_IDLE;
            end
         end
         RX_START: begin
            // A start bit that votes high at its centre was noise.
            if (bitMid_s && voted_s) begin
               nextState_s = RX_IDLE;
            end else if (bitEnd_s) begin
               nextState_s = RX_DATA;
            end else begin
               nextState_s = RX_START;
            end
         end
         RX_DATA: begin
            if (bitEnd_s && (bitCnt_r == wlEff_s)) begin
               nextState_s = PEN ? RX_PAR : RX_STOP1;
            end else begin
               nextState_s = RX_DATA;
            end
         end
         RX_PAR: begin
            if (bitEnd_s) begin
               nextState_s = RX_STOP1;
            end else begin
               nextState_s = RX_PAR;
            end
         end
         RX_STOP1: begin
            // Single stop bit: finish at its centre without waiting for its end.
            if (bitMid_s && !STB) begin
               nextState_s = voted_s ? RX_IDLE : RX_MWAIT;
            end else if (bitEnd_s && STB) begin
               nextState_s = RX_STOP2;
            end else begin
               nextState_s = RX_STOP1;
            end
         end
         RX_STOP2: begin
            if (bitMid_s) begin
               nextState_s = (stop1Bit_r && voted_s) ? RX_IDLE : RX_MWAIT;
            end else begin
               nextState_s = RX_STOP2;
            end
         end
         RX_MWAIT: begin
            // After a framing error, a held-low line must not look like a start.
            if (bitMid_s && voted_s) begin
               nextState_s = RX_IDLE;
            end else begin
               nextState_s = RX_MWAIT;
            end
         end
         default: begin
            nextState_s = RX_IDLE;
         end
      endcase
   end

   // FSM output decode: datapath strobes.
   always_comb begin
      startDet_s = 1'b0;
      shiftEn_s  = 1'b0;
      parCap_s   = 1'b0;
      stop1Cap_s = 1'b0;
      complete_s = 1'b0;
      case (state_r)
         RX_IDLE:  startDet_s = RXCLK & ~sSin_s & ~RXCLEAR;
         RX_DATA:  shiftEn_s  = bitMid_s;
         RX_PAR:   parCap_s   = bitMid_s;
         RX_STOP1: begin
            stop1Cap_s = bitMid_s;
            complete_s = bitMid_s & ~STB;
         end
         RX_STOP2: complete_s = bitMid_s;
         default: begin
            startDet_s = 1'b0;
         end
      endcase
   end

   // Frame status evaluated in the completion cycle.
   always_comb begin
      dataPar_s = dataParity(9'(data_r), wlEff_s);
      if (state_r == RX_STOP2) begin
         feNow_s = ~(stop1Bit_r & voted_s);
      end else begin
         feNow_s = ~voted_s;
      end
      if (!PEN) begin
         peNow_s = 1'b0;
      end else if (SP) begin
         // Stick parity: the bit must equal ~EPS.
         peNow_s = (parBit_r != ~EPS);
      end else begin
         // Even (EPS=1): total ones must be even; odd (EPS=0): must be odd.
         peNow_s = dataPar_s ^ parBit_r ^ ~EPS;
      end
      biNow_s     = (data_r == {DATA_W{1'b0}}) & (~parBit_r | ~PEN) & feNow_s;
      handshake_s = DVALID & DREADY;
   end

   // Shift register and captured parity / first stop bit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bitCnt_r   <= 4'd0;
         data_r     <= {DATA_W{1'b0}};
         parBit_r   <= 1'b0;
         stop1Bit_r <= 1'b0;
      end else if (RXCLEAR) begin
         bitCnt_r <= 4'd0;
      end else if (startDet_s) begin
         bitCnt_r   <= 4'd0;
         data_r     <= {DATA_W{1'b0}};
         parBit_r   <= 1'b0;
         stop1Bit_r <= 1'b0;
      end else begin
         if (shiftEn_s) begin
            data_r   <= data_r | (DATA_W'(voted_s) << bitCnt_r);
            bitCnt_r <= bitCnt_r + 4'd1;
         end
         if (parCap_s) begin
            parBit_r <= voted_s;
         end
         if (stop1Cap_s) begin
            stop1Bit_r <= voted_s;
         end
      end
   end

   // Holding register with overrun detection.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DOUT    <= {DATA_W{1'b0}};
         PE      <= 1'b0;
         FE      <= 1'b0;
         BI      <= 1'b0;
         DVALID  <= 1'b0;
         OVERRUN <= 1'b0;
      end else if (RXCLEAR) begin
         DVALID  <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         OVERRUN <= 1'b0;
         if (complete_s) begin
            if (DVALID && !DREADY) begin
               OVERRUN <= 1'b1;
            end else begin
               DOUT   <= data_r;
               PE     <= peNow_s;
               FE     <= feNow_s;
               BI     <= biNow_s;
               DVALID <= 1'b1;
            end
         end else if (handshake_s) begin
            DVALID <= 1'b0;
         end
      end
   end

   // Character timeout: counts idle bit-times while a word waits unread.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         toTick_r <= {TICK_W{1'b0}};
         toBits_r <= {TO_W{1'b0}};
         TIMEOUT  <= 1'b0;
      end else if (RXCLEAR || handshake_s || startDet_s) begin
         toTick_r <= {TICK_W{1'b0}};
         toBits_r <= {TO_W{1'b0}};
         TIMEOUT  <= 1'b0;
      end else if (DVALID && (state_r == RX_IDLE) && RXCLK && !TIMEOUT) begin
         if (toTick_r == TICK_LAST) begin
            toTick_r <= {TICK_W{1'b0}};
            if (toBits_r == TO_LAST) begin
               TIMEOUT <= 1'b1;
            end else begin
               toBits_r <= toBits_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end else begin
            toTick_r <= toTick_r + {{(TICK_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_gen2.sv
module tb_uart_rx_gen2;

   localparam int OS    = 16;
   localparam int DW    = 9;
   localparam int TOB   = 40;
   localparam int RXDIV = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          RXCLK = 1'b0;
   logic          RXCLEAR = 1'b0;
   logic [3:0]    WL = 4'd8;
   logic          STB = 1'b0;
   logic          PEN = 1'b0;
   logic          EPS = 1'b0;
   logic          SP = 1'b0;
   logic          SIN = 1'b1;
   logic [DW-1:0] DOUT;
   logic          PE;
   logic          FE;
   logic          BI;
   logic          DVALID;
   logic          DREADY = 1'b0;
   logic          OVERRUN;
   logic          TIMEOUT;

   int checks = 0;
   int errors = 0;
   int ovCount = 0;

   uart_rx_gen2 #(.OVERSAMPLE(OS), .DATA_W(DW), .TO_BITS(TOB)) dut (
      .CLK(CLK), .RST_N(RST_N), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR),
      .WL(WL), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .SIN(SIN),
      .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .DVALID(DVALID),
      .DREADY(DREADY), .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   initial begin : rxclkGen
      int div;
      div = 0;
      forever begin
         @(negedge CLK);
         div = (div + 1) % RXDIV;
         RXCLK = (div == 0);
      end
   end

   always @(negedge CLK) begin
      if (OVERRUN === 1'b1) ovCount++;
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      while (!RXCLK) @(posedge CLK);
   endtask

   task automatic sendTicks(input logic v, input int n);
      for (int t = 0; t < n; t++) begin
         #1 SIN = v;
         tick();
      end
   endtask

   // One bit; g >= 0 inverts the line for that single tick.
   task automatic sendBit(input logic v, input int g);
      for (int t = 0; t < OS; t++) begin
         #1 SIN = (t == g) ? ~v : v;
         tick();
      end
   endtask

   function automatic int wlEff();
      return (WL < 4'd5) ? 5 : ((int'(WL) > DW) ? DW : int'(WL));
   endfunction

   // Full frame under the current format; glitchBit selects a data bit to spike.
   task automatic sendFrame(input logic [8:0] w, input logic pbit, input logic s1,
                            input logic s2, input int glitchBit);
      sendBit(1'b0, -1);
      for (int i = 0; i < wlEff(); i++) sendBit(w[i], (i == glitchBit) ? OS / 2 + 1 : -1);
      if (PEN) sendBit(pbit, -1);
      sendBit(s1, -1);
      if (STB) sendBit(s2, -1);
   endtask

   // Reference: expected word and status from the line-format rules.
   task automatic frameChk(input string tag, input logic [8:0] w, input logic pbit,
                           input logic s1, input logic s2);
      int d;
      int ones;
      logic eP;
      logic eF;
      logic eB;
      d = int'(w) & ((1 << wlEff()) - 1);
      ones = $countones(d) + int'(pbit);
      if (!PEN) eP = 1'b0;
      else if (SP) eP = (pbit != !EPS);
      else if (EPS) eP = (ones % 2) != 0;
      else eP = (ones % 2) != 1;
      eF = !s1 || (STB && !s2);
      eB = (d == 0) && (!PEN || !pbit) && eF;
      @(negedge CLK);
      check({tag, ".DVALID"}, 16'(DVALID), 16'd1);
      check({tag, ".DOUT"}, 16'(DOUT), 16'(d));
      check({tag, ".PE"}, 16'(PE), 16'(eP));
      check({tag, ".FE"}, 16'(FE), 16'(eF));
      check({tag, ".BI"}, 16'(BI), 16'(eB));
   endtask

   task automatic handshake();
      @(negedge CLK);
      DREADY = 1'b1;
      @(negedge CLK);
      DREADY = 1'b0;
   endtask

   initial begin : main
      int ov0;
      logic [8:0] w;
      logic pb;
      logic s1;
      logic s2;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst.DVALID", 16'(DVALID), 16'd0);
      check("rst.DOUT", 16'(DOUT), 16'd0);
      check("rst.PE", 16'(PE), 16'd0);
      check("rst.FE", 16'(FE), 16'd0);
      check("rst.BI", 16'(BI), 16'd0);
      check("rst.OVERRUN", 16'(OVERRUN), 16'd0);
      check("rst.TIMEOUT", 16'(TIMEOUT), 16'd0);
      RST_N = 1'b1;
      sendTicks(1'b1, 2 * OS);

      // 8N1 frame 0xA5, with load timing around the stop-bit centre
      WL = 4'd8;
      sendBit(1'b0, -1);
      for (int i = 0; i < 8; i++) sendBit(1'(8'hA5 >> i), -1);
      sendTicks(1'b1, 4);
      @(negedge CLK);
      check("a5.early", 16'(DVALID), 16'd0);
      sendTicks(1'b1, OS - 4);
      frameChk("a5", 9'h0A5, 1'b0, 1'b1, 1'b1);
      handshake();
      @(negedge CLK);
      check("a5.hs", 16'(DVALID), 16'd0);

      // 7-bit, even parity, wrong parity bit; then stick parity
      WL = 4'd7; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
      sendFrame(9'h041, 1'b1, 1'b1, 1'b1, -1);
      frameChk("par.even", 9'h041, 1'b1, 1'b1, 1'b1);
      check("par.evenPE", 16'(PE), 16'd1);
      handshake();
      SP = 1'b1; EPS = 1'b0;
      sendFrame(9'h041, 1'b1, 1'b1, 1'b1, -1);
      frameChk("par.stick", 9'h041, 1'b1, 1'b1, 1'b1);
      check("par.stickPE", 16'(PE), 16'd0);
      handshake();
      PEN = 1'b0; SP = 1'b0;

      // Break: 13 bit-times low, only one word, then a clean frame
      WL = 4'd8;
      ov0 = ovCount;
      sendTicks(1'b0, 13 * OS);
      sendTicks(1'b1, 2 * OS);
      frameChk("brk", 9'h000, 1'b0, 1'b0, 1'b0);
      check("brk.BI", 16'(BI), 16'd1);
      check("brk.noOverrun", 16'(ovCount - ov0), 16'd0);
      handshake();
      sendFrame(9'h03C, 1'b0, 1'b1, 1'b1, -1);
      sendTicks(1'b1, OS);
      frameChk("afterBrk", 9'h03C, 1'b0, 1'b1, 1'b1);
      handshake();

      // False start and mid-bit glitch rejection
      sendTicks(1'b0, 4);
      sendTicks(1'b1, 2 * OS);
      @(negedge CLK);
      check("falseStart", 16'(DVALID), 16'd0);
      sendFrame(9'h05A, 1'b0, 1'b1, 1'b1, 1);
      sendTicks(1'b1, OS);
      frameChk("glitch1", 9'h05A, 1'b0, 1'b1, 1'b1);
      handshake();
      sendFrame(9'h05A, 1'b0, 1'b1, 1'b1, 2);
      sendTicks(1'b1, OS);
      frameChk("glitch0", 9'h05A, 1'b0, 1'b1, 1'b1);
      handshake();

      // Overrun: second word dropped, first held
      ov0 = ovCount;
      sendFrame(9'h011, 1'b0, 1'b1, 1'b1, -1);
      sendTicks(1'b1, OS);
      sendFrame(9'h022, 1'b0, 1'b1, 1'b1, -1);
      sendTicks(1'b1, 2 * OS);
      frameChk("ovr", 9'h011, 1'b0, 1'b1, 1'b1);
      check("ovr.pulses", 16'(ovCount - ov0), 16'd1);
      handshake();
      @(negedge CLK);
      check("ovr.hs", 16'(DVALID), 16'd0);

      // 9-bit word, two stop bits, second stop low; then character timeout
      WL = 4'd9; STB = 1'b1;
      sendFrame(9'h1A5, 1'b0, 1'b1, 1'b0, -1);
      frameChk("stb", 9'h1A5, 1'b0, 1'b1, 1'b0);
      sendTicks(1'b1, (TOB - 1) * OS);
      @(negedge CLK);
      check("to.before", 16'(TIMEOUT), 16'd0);
      sendTicks(1'b1, 4 * OS);
      @(negedge CLK);
      check("to.after", 16'(TIMEOUT), 16'd1);
      handshake();
      @(negedge CLK);
      check("to.cleared", 16'(TIMEOUT), 16'd0);
      check("to.dvalid", 16'(DVALID), 16'd0);
      STB = 1'b0;

      // Abort clears a pending word
      WL = 4'd8;
      sendFrame(9'h077, 1'b0, 1'b1, 1'b1, -1);
      sendTicks(1'b1, OS);
      frameChk("clr.pre", 9'h077, 1'b0, 1'b1, 1'b1);
      @(negedge CLK);
      RXCLEAR = 1'b1;
      @(negedge CLK);
      RXCLEAR = 1'b0;
      @(negedge CLK);
      check("clr.dvalid", 16'(DVALID), 16'd0);
      sendTicks(1'b1, OS);

      // Randomized formats and frames
      ov0 = ovCount;
      for (int n = 0; n < 14; n++) begin
         WL  = 4'($urandom_range(0, 15));
         PEN = 1'($urandom_range(0, 1));
         EPS = 1'($urandom_range(0, 1));
         SP  = 1'($urandom_range(0, 1));
         STB = 1'($urandom_range(0, 1));
         w   = 9'($urandom_range(0, 511));
         pb  = 1'($urandom_range(0, 1));
         s1  = ($urandom_range(0, 3) != 0);
         s2  = ($urandom_range(0, 3) != 0);
         sendFrame(w, pb, s1, s2, -1);
         sendTicks(1'b1, 2 * OS);
         frameChk($sformatf("rnd%0d", n), w, pb, s1, s2);
         handshake();
         @(negedge CLK);
         check($sformatf("rnd%0d.hs", n), 16'(DVALID), 16'd0);
      end
      check("rnd.noOverrun", 16'(ovCount - ov0), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
